mux_two_src: RTL and testbench
==============================

# mux_two_src

Stimulus source that sits directly upstream of the 2:1 select mux. It generates the two data inputs `a` and `b` as programmable square waves and drives the select line `sel` from a debounced push button. Each debounced press toggles `sel`, so a bench or board user can flip the mux between its inputs. All state lives in a single clock domain. The raw button is the only asynchronous input.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: number of consecutive enabled cycles the synchronized button must differ from the debounced level before that level changes. Legal range is 2..255. The debounce counter is 8 bits.

Ports:
- `clk`  in  1  single clock; all flops are rising-edge.
- `rst`  in  1  asynchronous, active-high reset. It clears every flop immediately.
- `ena`  in  1  when low, the debounce counter, `deb`, `sel`, both divider counters and both waves hold, and `sel_pulse` is 0. The synchronizer still runs.
- `btn`  in  1  raw, asynchronous select button.
- `div_a`  in  4  half-period control for `a`. `a` toggles every `div_a`+1 enabled cycles.
- `div_b`  in  4  half-period control for `b`, same rule as `div_a`.
- `a`  out  1  square wave, mux data input A.
- `b`  out  1  square wave, mux data input B.
- `sel`  out  1  mux select. It toggles once per debounced press.
- `sel_pulse`  out  1  one-cycle strobe in the cycle after `sel` changes.
- `btn_deb`  out  1  debounced button level.

## Operation
- Synchronizer: two flops, `s1` <= `btn` and `s2` <= `s1`. Only `s2` is used downstream.
- Debouncer: 8-bit counter `dc` and level register `deb`; `btn_deb` = `deb`. Rules apply on enabled cycles only:
  - `s2` == `deb`: `dc` <= 0.
  - `s2` != `deb` and `dc` < `DEB_CYCLES`-1: `dc` <= `dc`+1.
  - `s2` != `deb` and `dc` == `DEB_CYCLES`-1: `deb` <= `s2` and `dc` <= 0.
  - Any single matching cycle restarts the count, which rejects bounces.
- Select toggle:
  - The edge on which `deb` goes 0→1 also does `sel` <= ~`sel` and `sel_pulse` <= 1.
  - On every other edge `sel_pulse` <= 0.
  - A 1→0 `deb` transition (release) leaves `sel` unchanged and produces no pulse.
- Wave generators, identical for `a`/`div_a`/`cnt_a` and `b`/`div_b`/`cnt_b`. On each enabled cycle:
  - `cnt_a` >= `div_a`: `cnt_a` <= 0 and `a` <= ~`a`.
  - Otherwise `cnt_a` <= `cnt_a`+1.
  - The ">=" comparison means that lowering `div_a` below the current count forces a toggle on the next enabled edge. The counter never wraps through 15.
  - The period of `a` is 2×(`div_a`+1) cycles. With `div_a`=0, `a` toggles every enabled cycle.
- Width rules: `cnt_a` and `cnt_b` are 4 bits; `dc` is 8 bits. There is no overflow path.
- Reset:
  - `rst` clears `s1`, `s2`, `dc`, `deb`, `sel`, `sel_pulse`, `cnt_a`, `cnt_b`, `a` and `b` to 0.
  - All outputs reset to 0.
  - Reset asserted mid-debounce or mid-period discards that progress. No toggle is produced on reset release.

## Timing
- Button latency: `btn` goes high before edge 0 and stays high. Then:
  - `s2`=1 after edge 1.
  - Mismatches are counted on edges 2..1+`DEB_CYCLES`.
  - `deb`=1 and `sel` toggled after edge 1+`DEB_CYCLES`.
  - `sel_pulse` is high for exactly that one cycle.
- Every cycle with `ena` low extends the debounce latency by one cycle.
- Wave latency: after `rst` is released, the first toggle of `a` occurs on the (`div_a`+1)-th enabled edge.
- Divider updates: a change to `div_a` or `div_b` takes effect on the next enabled edge. No glitch occurs beyond the forced toggle described in Operation.
- Simultaneous events are independent: a `deb` rise and a wave toggle on the same edge both take effect.
- `ena` falling on the confirming edge: no update, no pulse. The counter holds at `DEB_CYCLES`-1 and confirms on the next enabled cycle if `s2` still mismatches.

## Test plan
- Reset: hold `rst`=1 with `btn`=1 and `ena`=1 → `a`, `b`, `sel`, `sel_pulse` and `btn_deb` all 0. Assert `rst` for one cycle mid-count → all outputs 0 immediately.
- Waves: `div_a`=0, `div_b`=3, `ena`=1 from reset → `a` toggles every edge (period 2) and `b` first toggles on edge 4 (period 8). Drop `ena` for 5 cycles → both hold, then resume the same phase.
- Clean press (`DEB_CYCLES`=4): `btn` goes 0→1 and is held → `sel` goes 0→1 after edge 5 and `sel_pulse` is high for one cycle. Release `btn` → `btn_deb` falls 6 edges later, `sel` stays 1 and there is no pulse. A second press gives `sel`=0.
- Bounce: `s2` pattern 1,1,1,0,1,1,1,1 → no change until the 4th consecutive 1. `sel` toggles exactly once.
- Divider shrink: `div_a`=15, wait until `cnt_a`=10, set `div_a`=2 → `a` toggles on the next edge, `cnt_a`=0, and the period is then 6.
- `ena` gating on the confirm edge: hold `ena` low when `dc`=3 with `s2` mismatching → no pulse. Raise `ena` → `sel` toggles and `sel_pulse` fires on the next edge.

Source files
------------

// File: rtl/mux_two_src.sv
// Stimulus source for a 2:1 mux: two programmable square waves on a/b and a
// select line toggled by a synchronized, debounced push button.
module mux_two_src #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       btn,
    input  logic [3:0] div_a,
    input  logic [3:0] div_b,
    output logic       a,
    output logic       b,
    output logic       sel,
    output logic       sel_pulse,
    output logic       btn_deb
);

    localparam int unsigned DC_W  = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [DC_W-1:0]  dc;
    logic [DC_W-1:0]  dc_nxt_c;
    logic             deb;
    logic             deb_nxt_c;
    logic             deb_rise_c;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_a_nxt_c;
    logic [CNT_W-1:0] cnt_b_nxt_c;
    logic             a_nxt_c;
    logic             b_nxt_c;

    // Two-flop synchronizer for the raw button; runs regardless of ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce: level changes only after DEB_CYCLES consecutive enabled mismatches.
    always_comb begin
        dc_nxt_c   = dc;
        deb_nxt_c  = deb;
        deb_rise_c = 1'b0;
        if (ena) begin
            if (s2 == deb) begin
                dc_nxt_c = '0;
            end else if (dc >= DC_LAST) begin
                dc_nxt_c   = '0;
                deb_nxt_c  = s2;
                deb_rise_c = s2;
            end else begin
                dc_nxt_c = dc + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc        <= '0;
            deb       <= 1'b0;
            sel       <= 1'b0;
            sel_pulse <= 1'b0;
        end else begin
            dc        <= dc_nxt_c;
            deb       <= deb_nxt_c;
            sel       <= sel ^ deb_rise_c;
            sel_pulse <= deb_rise_c;
        end
    end

    assign btn_deb = deb;

    // Wave dividers; ">=" makes a shrunk divider force a toggle instead of wrapping.
    always_comb begin
        cnt_a_nxt_c = cnt_a;
        cnt_b_nxt_c = cnt_b;
        a_nxt_c     = a;
        b_nxt_c     = b;
        if (ena) begin
            if (cnt_a >= div_a) begin
                cnt_a_nxt_c = '0;
                a_nxt_c     = ~a;
            end else begin
                cnt_a_nxt_c = cnt_a + CNT_W'(1);
            end
            if (cnt_b >= div_b) begin
                cnt_b_nxt_c = '0;
                b_nxt_c     = ~b;
            end else begin
                cnt_b_nxt_c = cnt_b + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
        end else begin
            cnt_a <= cnt_a_nxt_c;
            cnt_b <= cnt_b_nxt_c;
            a     <= a_nxt_c;
            b     <= b_nxt_c;
        end
    end

endmodule

// File: tb/tb_mux_two_src.sv
// Bench for mux_two_src: behavioural model compared every cycle plus
// hand-computed directed expectations.
module tb_mux_two_src;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] div_a = 4'd0;
    logic [3:0] div_b = 4'd3;
    logic       a, b, sel, sel_pulse, btn_deb;

    int checks = 0;
    int errors = 0;

    mux_two_src #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .btn       (btn),
        .div_a     (div_a),
        .div_b     (div_b),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .sel_pulse (sel_pulse),
        .btn_deb   (btn_deb)
    );

    always #5 clk = ~clk;

    // Model: button seen two edges late; level flips on the DEB-th consecutive
    // enabled mismatch; each wave flips once its elapsed run reaches its divider.
    logic m_b1, m_b2, m_deb, m_sel, m_pulse, m_a, m_b;
    int   m_run, m_since_a, m_since_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_b1 <= 1'b0; m_b2 <= 1'b0; m_deb <= 1'b0; m_sel <= 1'b0;
            m_pulse <= 1'b0; m_a <= 1'b0; m_b <= 1'b0;
            m_run <= 0; m_since_a <= 0; m_since_b <= 0;
        end else begin
            m_b1 <= btn;
            m_b2 <= m_b1;
            m_pulse <= 1'b0;
            if (ena) begin
                if (m_b2 == m_deb) begin
                    m_run <= 0;
                end else if (m_run + 1 == DEB) begin
                    m_run <= 0;
                    m_deb <= m_b2;
                    if (m_b2) begin
                        m_sel   <= ~m_sel;
                        m_pulse <= 1'b1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
                if (m_since_a >= int'(div_a)) begin
                    m_since_a <= 0;
                    m_a <= ~m_a;
                end else begin
                    m_since_a <= m_since_a + 1;
                end
                if (m_since_b >= int'(div_b)) begin
                    m_since_b <= 0;
                    m_b <= ~m_b;
                end else begin
                    m_since_b <= m_since_b + 1;
                end
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check1("model_a", a, m_a);
        check1("model_b", b, m_b);
        check1("model_sel", sel, m_sel);
        check1("model_sel_pulse", sel_pulse, m_pulse);
        check1("model_btn_deb", btn_deb, m_deb);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic       a_before;
        int         pcount;
        int         guard;

        // Reset held with button pressed and enable high
        #1 rst = 1'b1;
        btn = 1'b1;
        step(2);
        check1("rst_a", a, 1'b0);
        check1("rst_b", b, 1'b0);
        check1("rst_sel", sel, 1'b0);
        check1("rst_pulse", sel_pulse, 1'b0);
        check1("rst_btn_deb", btn_deb, 1'b0);
        btn = 1'b0;
        step(2);
        rst = 1'b0;

        // Waves: div_a=0 toggles every edge, div_b=3 first toggles on edge 4
        step(1);
        check1("wave_a_edge1", a, 1'b1);
        check1("wave_b_edge1", b, 1'b0);
        step(2);
        check1("wave_a_edge3", a, 1'b1);
        check1("wave_b_edge3", b, 1'b0);
        step(1);
        check1("wave_a_edge4", a, 1'b0);
        check1("wave_b_edge4", b, 1'b1);
        ena = 1'b0;
        step(5);
        check1("hold_a", a, 1'b0);
        check1("hold_b", b, 1'b1);
        ena = 1'b1;
        step(1);
        check1("resume_a", a, 1'b1);
        check1("resume_b", b, 1'b1);

        // Clean press: confirmation 1+DEB edges after edge 0
        btn = 1'b1;
        step(5);
        check1("press_sel_early", sel, 1'b0);
        step(1);
        check1("press_sel", sel, 1'b1);
        check1("press_pulse", sel_pulse, 1'b1);
        check1("press_deb", btn_deb, 1'b1);
        step(1);
        check1("press_pulse_off", sel_pulse, 1'b0);

        // Release: level falls 6 edges later, no toggle
        btn = 1'b0;
        step(5);
        check1("rel_deb_early", btn_deb, 1'b1);
        step(1);
        check1("rel_deb", btn_deb, 1'b0);
        check1("rel_sel", sel, 1'b1);
        check1("rel_pulse", sel_pulse, 1'b0);
        step(2);

        // Second press returns sel to 0
        btn = 1'b1;
        step(6);
        check1("press2_sel", sel, 1'b0);
        check1("press2_pulse", sel_pulse, 1'b1);
        btn = 1'b0;
        step(8);

        // Bounce: s2 sees 1,1,1,0,1,1,1,1 -> confirm on 4th consecutive 1
        pat = 8'b1111_0111;
        pcount = 0;
        for (int i = 0; i < 14; i++) begin
            btn = (i < 8) ? pat[i] : 1'b1;
            step(1);
            if (sel_pulse) pcount++;
            if (i == 8) check1("bounce_sel_early", sel, 1'b0);
            if (i == 9) check1("bounce_sel", sel, 1'b1);
        end
        checks++;
        if (pcount != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", pcount);
        end

        // Enable dropped on the confirming edge
        btn = 1'b0;
        step(8);
        btn = 1'b1;
        step(5);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check1("gate_pulse", sel_pulse, 1'b0);
            check1("gate_sel", sel, 1'b1);
        end
        ena = 1'b1;
        step(1);
        check1("gate_confirm_sel", sel, 1'b0);
        check1("gate_confirm_pulse", sel_pulse, 1'b1);
        step(1);
        check1("gate_pulse_off", sel_pulse, 1'b0);

        // Divider shrink from 15 to 2 at count 10
        div_a = 4'd15;
        guard = 0;
        while (m_since_a != 10 && guard < 40) begin
            step(1);
            guard++;
        end
        checks++;
        if (m_since_a != 10) begin
            errors++;
            $display("FAIL shrink_wait: count got %0d expected 10", m_since_a);
        end
        a_before = m_a;
        div_a = 4'd2;
        step(1);
        check1("shrink_forced", a, ~a_before);
        step(2);
        check1("shrink_hold", a, ~a_before);
        step(1);
        check1("shrink_period", a, a_before);
        step(2);
        check1("shrink_hold2", a, a_before);
        step(1);
        check1("shrink_period2", a, ~a_before);

        // Reset pulse mid-debounce clears outputs immediately
        btn = 1'b0;
        step(8);
        btn = 1'b1;
        step(3);
        rst = 1'b1;
        #1;
        check1("midrst_a", a, 1'b0);
        check1("midrst_b", b, 1'b0);
        check1("midrst_sel", sel, 1'b0);
        check1("midrst_pulse", sel_pulse, 1'b0);
        check1("midrst_deb", btn_deb, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
